// File: rtl/ag_pkg.sv
// Shared types and constants for the address-generation latch stage.
// The occupancy enum, the decode bundle and the buffered entry live here so
// the buffer and the top agree on one layout.
package ag_pkg;

    localparam int AG_DEPTH = 2;
    localparam int EA_W     = 32;

    // Occupancy of the two-entry buffer
    typedef enum logic [1:0] {
        AG_EMPTY = 2'd0,
        AG_ONE   = 2'd1,
        AG_FULL  = 2'd2
    } ag_occ_e;

    // Everything DE hands over in one push
    typedef struct packed {
        logic            re;
        logic            we;
        logic            rmsel;
        logic            ro_needed;
        logic            rm_needed;
        logic [1:0]      alusel;
        logic [2:0]      jmp;
        logic [7:0]      modrm;
        logic [15:0]     sreg;
        logic [15:0]     ptr;
        logic [EA_W-1:0] dval;
        logic [EA_W-1:0] sval;
        logic [EA_W-1:0] disp;
        logic [EA_W-1:0] flags;
        logic [EA_W-1:0] flag_ld;
    } de_bundle_t;

    // One buffer slot: the decode bundle plus the address computed at push
    typedef struct packed {
        de_bundle_t      de;
        logic [EA_W-1:0] ea;
    } ag_entry_t;

    // Effective address: register-memory operand uses source value plus
    // displacement, wrapping modulo 2^EA_W; otherwise there is no address.
    function automatic logic [EA_W-1:0] ag_calc_ea(
        input logic            rmsel,
        input logic [EA_W-1:0] sval,
        input logic [EA_W-1:0] disp
    );
        logic [EA_W-1:0] sum;
        sum = sval + disp;
        return rmsel ? sum : '0;
    endfunction

endpackage

// File: rtl/ag_fifo2.sv
// Two-entry register buffer with push, pop and flush.
// The head is held in its own register so that, once the buffer drains, the
// outputs keep showing the last entry rather than whatever stale slot the
// read pointer happens to land on.
module ag_fifo2
    import ag_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push_i,
    input  logic      pop_i,
    input  logic      flush_i,
    input  ag_entry_t entry_i,
    output logic      valid_o,
    output logic      full_o,
    output ag_occ_e   count_o,
    output ag_entry_t head_o
);

    ag_entry_t mem_q [AG_DEPTH];
    ag_entry_t head_q, head_d;
    ag_occ_e   count_q, count_d;
    logic      wr_ptr_q, wr_ptr_d;
    logic      rd_ptr_q, rd_ptr_d;
    logic      full_q;
    logic      wr_en, rd_en;

    // Next-state occupancy, pointer movement and the next visible head
    always_comb begin
        rd_en = pop_i && (count_q != AG_EMPTY);
        // A push while full is only taken if the head leaves in the same cycle
        wr_en = push_i && ((count_q != AG_FULL) || rd_en);
        if (flush_i) begin
            rd_en = 1'b0;
            wr_en = 1'b0;
        end

        count_d = count_q;
        case (count_q)
            AG_EMPTY: if (wr_en) count_d = AG_ONE;
            AG_ONE: begin
                if (wr_en && !rd_en)      count_d = AG_FULL;
                else if (!wr_en && rd_en) count_d = AG_EMPTY;
            end
            AG_FULL:  if (rd_en && !wr_en) count_d = AG_ONE;
            default:  count_d = AG_EMPTY;
        endcase

        wr_ptr_d = wr_en ? ~wr_ptr_q : wr_ptr_q;
        rd_ptr_d = rd_en ? ~rd_ptr_q : rd_ptr_q;

        if (flush_i) begin
            count_d  = AG_EMPTY;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end

        // New head is the slot at the next read pointer, bypassing the write
        // when that slot is being filled this very edge
        head_d = head_q;
        if (count_d != AG_EMPTY) begin
            if (wr_en && (wr_ptr_q == rd_ptr_d))
                head_d = entry_i;
            else
                head_d = mem_q[rd_ptr_d];
        end
    end

    // Control state: occupancy, pointers, registered full flag, head copy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= AG_EMPTY;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            full_q   <= 1'b0;
            head_q   <= '0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            full_q   <= (count_d == AG_FULL);
            head_q   <= head_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < AG_DEPTH; gi++) begin : g_slot
            // Each slot loads only when it is the write target of an accepted push
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    mem_q[gi] <= '0;
                else if (wr_en && (wr_ptr_q == 1'(gi)))
                    mem_q[gi] <= entry_i;
            end
        end
    endgenerate

    assign valid_o = (count_q != AG_EMPTY);
    assign full_o  = full_q;
    assign count_o = count_q;
    assign head_o  = head_q;

endmodule

// File: rtl/ag_latch_stage.sv
// Receiving end of the DE->AG interface. Captures the decode bundle on a
// push, computes the effective address, and presents the oldest held entry
// to the memory-read stage. Two entries absorb one cycle of downstream stall.
// Optional feature: define AG_PERF_EN to add the ag_stall_cnt output, a
// saturating count of cycles where a valid head was not accepted.
module ag_latch_stage
    import ag_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ag_vin,
    input  logic        ld_ag,
    input  logic        ag_flush,
    input  logic        de_re,
    input  logic        de_we,
    input  logic        de_rmsel,
    input  logic        de_ro_needed,
    input  logic        de_rm_needed,
    input  logic [1:0]  de_alusel,
    input  logic [2:0]  de_jmp,
    input  logic [7:0]  de_modrm,
    input  logic [15:0] de_sreg,
    input  logic [15:0] de_ptr,
    input  logic [31:0] de_dval,
    input  logic [31:0] de_sval,
    input  logic [31:0] de_disp,
    input  logic [31:0] de_flags,
    input  logic [31:0] de_flag_ld,
    input  logic        mr_ready,
    output logic        ag_full,
    output logic        ag_ovf,
    output logic        ag_v,
`ifdef AG_PERF_EN
    output logic [15:0] ag_stall_cnt,
`endif
    output logic        ag_re,
    output logic        ag_we,
    output logic        ag_rmsel,
    output logic        ag_ro_needed,
    output logic        ag_rm_needed,
    output logic [1:0]  ag_alusel,
    output logic [2:0]  ag_jmp,
    output logic [7:0]  ag_modrm,
    output logic [15:0] ag_sreg,
    output logic [15:0] ag_ptr,
    output logic [31:0] ag_dval,
    output logic [31:0] ag_sval,
    output logic [31:0] ag_disp,
    output logic [31:0] ag_flags,
    output logic [31:0] ag_flag_ld,
    output logic [31:0] ag_ea
);

    de_bundle_t in_bundle;
    ag_entry_t  in_entry;
    ag_entry_t  head;
    ag_occ_e    count;
    logic       push;
    logic       pop;
    logic       valid;
    logic       full;
    logic       drop;
    logic       ovf_q, ovf_d;

    // Gather the decode fields and attach the effective address
    always_comb begin
        in_bundle.re        = de_re;
        in_bundle.we        = de_we;
        in_bundle.rmsel     = de_rmsel;
        in_bundle.ro_needed = de_ro_needed;
        in_bundle.rm_needed = de_rm_needed;
        in_bundle.alusel    = de_alusel;
        in_bundle.jmp       = de_jmp;
        in_bundle.modrm     = de_modrm;
        in_bundle.sreg      = de_sreg;
        in_bundle.ptr       = de_ptr;
        in_bundle.dval      = de_dval;
        in_bundle.sval      = de_sval;
        in_bundle.disp      = de_disp;
        in_bundle.flags     = de_flags;
        in_bundle.flag_ld   = de_flag_ld;
        in_entry.de         = in_bundle;
        in_entry.ea         = ag_calc_ea(de_rmsel, de_sval, de_disp);
    end

    assign push = ag_vin & ld_ag;
    assign pop  = valid & mr_ready;

    ag_fifo2 u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (ag_flush),
        .entry_i (in_entry),
        .valid_o (valid),
        .full_o  (full),
        .count_o (count),
        .head_o  (head)
    );

    // A push is lost only when full with no pop to make room; a flush
    // squashes the push anyway so it does not count as an overflow
    assign drop  = push & (count == AG_FULL) & ~pop & ~ag_flush;
    assign ovf_d = ovf_q | drop;

    // Sticky overflow, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf_q <= 1'b0;
        else        ovf_q <= ovf_d;
    end

`ifdef AG_PERF_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (valid && !mr_ready && (stall_cnt_q != 16'hFFFF))
            stall_cnt_d = stall_cnt_q + 16'd1;
    end

    // Saturating stall counter; survives flushes, cleared by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_cnt_q <= 16'd0;
        else        stall_cnt_q <= stall_cnt_d;
    end

    assign ag_stall_cnt = stall_cnt_q;
`endif

    assign ag_full      = full;
    assign ag_ovf       = ovf_q;
    assign ag_v         = valid;
    assign ag_re        = head.de.re;
    assign ag_we        = head.de.we;
    assign ag_rmsel     = head.de.rmsel;
    assign ag_ro_needed = head.de.ro_needed;
    assign ag_rm_needed = head.de.rm_needed;
    assign ag_alusel    = head.de.alusel;
    assign ag_jmp       = head.de.jmp;
    assign ag_modrm     = head.de.modrm;
    assign ag_sreg      = head.de.sreg;
    assign ag_ptr       = head.de.ptr;
    assign ag_dval      = head.de.dval;
    assign ag_sval      = head.de.sval;
    assign ag_disp      = head.de.disp;
    assign ag_flags     = head.de.flags;
    assign ag_flag_ld   = head.de.flag_ld;
    assign ag_ea        = head.ea;

endmodule

// File: tb/tb_ag_latch_stage.sv
// Directed bench for ag_latch_stage with hand-computed expectations.
// Define AG_PERF_EN to also exercise the stall counter.
`timescale 1ns/1ps
module tb_ag_latch_stage;

    logic        clk;
    logic        rst_n;
    logic        ag_vin, ld_ag, ag_flush;
    logic        de_re, de_we, de_rmsel, de_ro_needed, de_rm_needed;
    logic [1:0]  de_alusel;
    logic [2:0]  de_jmp;
    logic [7:0]  de_modrm;
    logic [15:0] de_sreg, de_ptr;
    logic [31:0] de_dval, de_sval, de_disp, de_flags, de_flag_ld;
    logic        mr_ready;
    logic        ag_full, ag_ovf, ag_v;
    logic        ag_re, ag_we, ag_rmsel, ag_ro_needed, ag_rm_needed;
    logic [1:0]  ag_alusel;
    logic [2:0]  ag_jmp;
    logic [7:0]  ag_modrm;
    logic [15:0] ag_sreg, ag_ptr;
    logic [31:0] ag_dval, ag_sval, ag_disp, ag_flags, ag_flag_ld, ag_ea;
`ifdef AG_PERF_EN
    logic [15:0] ag_stall_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    ag_latch_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ag_vin       (ag_vin),
        .ld_ag        (ld_ag),
        .ag_flush     (ag_flush),
        .de_re        (de_re),
        .de_we        (de_we),
        .de_rmsel     (de_rmsel),
        .de_ro_needed (de_ro_needed),
        .de_rm_needed (de_rm_needed),
        .de_alusel    (de_alusel),
        .de_jmp       (de_jmp),
        .de_modrm     (de_modrm),
        .de_sreg      (de_sreg),
        .de_ptr       (de_ptr),
        .de_dval      (de_dval),
        .de_sval      (de_sval),
        .de_disp      (de_disp),
        .de_flags     (de_flags),
        .de_flag_ld   (de_flag_ld),
        .mr_ready     (mr_ready),
        .ag_full      (ag_full),
        .ag_ovf       (ag_ovf),
        .ag_v         (ag_v),
`ifdef AG_PERF_EN
        .ag_stall_cnt (ag_stall_cnt),
`endif
        .ag_re        (ag_re),
        .ag_we        (ag_we),
        .ag_rmsel     (ag_rmsel),
        .ag_ro_needed (ag_ro_needed),
        .ag_rm_needed (ag_rm_needed),
        .ag_alusel    (ag_alusel),
        .ag_jmp       (ag_jmp),
        .ag_modrm     (ag_modrm),
        .ag_sreg      (ag_sreg),
        .ag_ptr       (ag_ptr),
        .ag_dval      (ag_dval),
        .ag_sval      (ag_sval),
        .ag_disp      (ag_disp),
        .ag_flags     (ag_flags),
        .ag_flag_ld   (ag_flag_ld),
        .ag_ea        (ag_ea)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%08h", tag, got);
        end
    endtask

    // Advance one edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one DE bundle with a push strobe
    task automatic drive_push(input logic rmsel, input logic [31:0] sval,
                              input logic [31:0] disp, input logic [1:0] alusel,
                              input logic [7:0] modrm);
        ag_vin    = 1'b1;
        ld_ag     = 1'b1;
        de_rmsel  = rmsel;
        de_sval   = sval;
        de_disp   = disp;
        de_alusel = alusel;
        de_modrm  = modrm;
    endtask

    task automatic idle();
        ag_vin = 1'b0;
        ld_ag  = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        ag_vin = 0; ld_ag = 0; ag_flush = 0; mr_ready = 0;
        de_re = 1; de_we = 0; de_rmsel = 0; de_ro_needed = 1; de_rm_needed = 1;
        de_alusel = 0; de_jmp = 3'd5; de_modrm = 0; de_sreg = 16'h1234; de_ptr = 16'h5678;
        de_dval = 32'hDEADBEEF; de_sval = 0; de_disp = 0; de_flags = 32'h11; de_flag_ld = 32'h22;
        #2;
        check_val("rst_ag_v", ag_v, 0);
        check_val("rst_full", ag_full, 0);
        check_val("rst_ovf", ag_ovf, 0);
        check_val("rst_ea", ag_ea, 0);
        check_val("rst_dval", ag_dval, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // 1: ADD M[ECX] EAX, EA = 1 + 1
        mr_ready = 1'b1;
        drive_push(1'b1, 32'd1, 32'd1, 2'b11, 8'h01);
        tick();
        idle();
        check_val("t1_ag_v", ag_v, 1);
        check_val("t1_ea", ag_ea, 32'd2);
        check_val("t1_alusel", ag_alusel, 2'b11);
        check_val("t1_dval", ag_dval, 32'hDEADBEEF);
        check_val("t1_sreg", ag_sreg, 16'h1234);
        tick();
        check_val("t1_pop_ag_v", ag_v, 0);
        check_val("t1_hold_ea", ag_ea, 32'd2);

        // 2: no register-memory operand -> EA 0
        drive_push(1'b0, 32'd5, 32'd7, 2'b01, 8'hC0);
        tick();
        idle();
        check_val("t2_ag_v", ag_v, 1);
        check_val("t2_ea", ag_ea, 0);
        check_val("t2_modrm", ag_modrm, 8'hC0);
        tick();

        // 3: address wraps modulo 2^32
        drive_push(1'b1, 32'hFFFFFFFF, 32'd2, 2'b00, 8'h02);
        tick();
        idle();
        check_val("t3_ea", ag_ea, 32'h00000001);
        tick();
        check_val("t3_empty", ag_v, 0);

        // 4/5: stall, fill, push&pop while full, then overflow
        mr_ready = 1'b0;
        drive_push(1'b1, 32'h10, 32'h0, 2'b00, 8'hA0);   // A
        tick();
        check_val("t4_a_v", ag_v, 1);
        check_val("t4_a_full", ag_full, 0);
        check_val("t4_a_ea", ag_ea, 32'h10);
        drive_push(1'b1, 32'h20, 32'h0, 2'b00, 8'hB0);   // B
        tick();
        check_val("t4_b_full", ag_full, 1);
        check_val("t4_b_head", ag_ea, 32'h10);
        mr_ready = 1'b1;
        drive_push(1'b1, 32'h30, 32'h0, 2'b00, 8'hC1);   // C with pop of A
        tick();
        check_val("t5_pp_full", ag_full, 1);
        check_val("t5_pp_ovf", ag_ovf, 0);
        check_val("t5_pp_head", ag_ea, 32'h20);
        mr_ready = 1'b0;
        drive_push(1'b1, 32'h40, 32'h0, 2'b00, 8'hD0);   // D dropped
        tick();
        idle();
        check_val("t4_drop_ovf", ag_ovf, 1);
        check_val("t4_drop_full", ag_full, 1);
        check_val("t4_drop_head", ag_ea, 32'h20);
        mr_ready = 1'b1;
        tick();
        check_val("t5_drain1_ea", ag_ea, 32'h30);
        check_val("t5_drain1_full", ag_full, 0);
        check_val("t5_drain1_v", ag_v, 1);
        tick();
        check_val("t5_drain2_v", ag_v, 0);
        check_val("t5_ovf_sticky", ag_ovf, 1);

        // 6: flush with a push in the same cycle
        mr_ready = 1'b0;
        drive_push(1'b1, 32'h50, 32'h0, 2'b00, 8'h50);
        tick();
        drive_push(1'b1, 32'h60, 32'h0, 2'b00, 8'h60);
        ag_flush = 1'b1;
        tick();
        ag_flush = 1'b0;
        idle();
        check_val("t6_flush_v", ag_v, 0);
        check_val("t6_flush_full", ag_full, 0);
        check_val("t6_flush_ovf", ag_ovf, 1);
        drive_push(1'b1, 32'h70, 32'h1, 2'b10, 8'h70);
        tick();
        idle();
        check_val("t6_after_v", ag_v, 1);
        check_val("t6_after_ea", ag_ea, 32'h71);

        // Asynchronous reset in the middle of a cycle with a push pending
        drive_push(1'b1, 32'h80, 32'h0, 2'b01, 8'h80);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_val("arst_v", ag_v, 0);
        check_val("arst_ea", ag_ea, 0);
        check_val("arst_ovf", ag_ovf, 0);
        check_val("arst_alusel", ag_alusel, 0);
        check_val("arst_full", ag_full, 0);
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_val("arst_post_v", ag_v, 0);

`ifdef AG_PERF_EN
        check_val("perf_rst", ag_stall_cnt, 0);
        mr_ready = 1'b0;
        drive_push(1'b1, 32'h90, 32'h0, 2'b00, 8'h90);
        tick();
        idle();
        for (int i = 0; i < 4; i++) tick();
        check_val("perf_4stall", ag_stall_cnt, 4);
        ag_flush = 1'b1;
        tick();
        ag_flush = 1'b0;
        check_val("perf_flush_cnt", ag_stall_cnt, 5);
        tick();
        check_val("perf_empty_hold", ag_stall_cnt, 5);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard time limit so the run always ends
    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
